// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
//   Parametrised UART receiver. It has an integrated oversampling tick
//   generator and 3-sample majority voting per bit. Parity and stop-bit modes
//   are selected at runtime. Received words go to a single-entry holding
//   register with a valid/ack handshake.
//
// Parameters
//   DATA_BITS   data bits per frame (5..9), LSB first
//   OVERSAMPLE  sample ticks per bit (even, 8..32)
//   DIV_W       width of the divider input
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   divider      sample tick period minus 1, in clk cycles
//   parity_mode  00/11 none, 01 even, 10 odd (latched at start of frame)
//   two_stop     1 = two stop bits checked (latched at start of frame)
//   rx_line      asynchronous serial input, idle high
//   rx_data      holding register contents
//   rx_valid     holding register full
//   rx_ack       consumer takes the word while rx_valid=1
//   parity_err   1-cycle pulse, parity mismatch
//   frame_err    1-cycle pulse, stop bit sampled low
//   overrun_err  1-cycle pulse, good frame dropped because register full
//   busy         receiver is inside a frame
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DIV_W-1:0]     divider,
   input  logic [1:0]           parity_mode,
   input  logic                 two_stop,
   input  logic                 rx_line,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ack,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int M  = OVERSAMPLE / 2;
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [SW-1:0] C_PRE  = SW'(M - 1);
   localparam logic [SW-1:0] C_MID  = SW'(M);
   localparam logic [SW-1:0] C_DEC  = SW'(M + 1);
   localparam logic [SW-1:0] C_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // registers
   logic                 r_sync1, r_sync2;
   logic [DIV_W-1:0]     r_tick_cnt;
   state_t               r_state;
   logic [SW-1:0]        r_samp_ctr;
   logic [BW-1:0]        r_bit_ctr;
   logic                 r_stop_ctr;
   logic                 r_v0, r_v1;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_bit;
   logic [1:0]           r_par_mode;
   logic                 r_two_stop;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_rx_valid;
   logic                 r_parity_err, r_frame_err, r_overrun_err;

   // combinational next values
   state_t               w_state_next;
   logic [SW-1:0]        w_samp_next;
   logic [BW-1:0]        w_bit_next;
   logic                 w_stop_next;
   logic                 w_v0_next, w_v1_next;
   logic [DATA_BITS-1:0] w_shift_next;
   logic                 w_par_bit_next;
   logic [1:0]           w_par_mode_next;
   logic                 w_two_stop_next;
   logic [DATA_BITS-1:0] w_rx_data_next;
   logic                 w_rx_valid_next;
   logic                 w_parity_err_next, w_frame_err_next, w_overrun_err_next;

   logic                 w_rx_s;
   logic                 w_tick;
   logic                 w_vote;
   logic                 w_par_en;
   logic                 w_par_fail;

   assign w_rx_s = r_sync2;

   // ">=" rather than "==" so that lowering the divider below the current
   // count still produces a wrap at the next compare instead of a long run-out.
   assign w_tick = (r_tick_cnt >= divider);

   // Third sample is the live one on the decision tick.
   assign w_vote = (r_v0 & r_v1) | (r_v0 & w_rx_s) | (r_v1 & w_rx_s);

   assign w_par_en   = (r_par_mode == 2'b01) || (r_par_mode == 2'b10);
   // Even parity expects XOR(data, parity)=0, odd expects 1; mode bit 1 is
   // exactly that expected value for the two enabled encodings.
   assign w_par_fail = ((^r_shift) ^ r_par_bit) != r_par_mode[1];

   always_comb begin
      w_state_next       = r_state;
      w_samp_next        = r_samp_ctr;
      w_bit_next         = r_bit_ctr;
      w_stop_next        = r_stop_ctr;
      w_v0_next          = r_v0;
      w_v1_next          = r_v1;
      w_shift_next       = r_shift;
      w_par_bit_next     = r_par_bit;
      w_par_mode_next    = r_par_mode;
      w_two_stop_next    = r_two_stop;
      w_rx_data_next     = r_rx_data;
      w_rx_valid_next    = r_rx_valid & ~rx_ack;
      w_parity_err_next  = 1'b0;
      w_frame_err_next   = 1'b0;
      w_overrun_err_next = 1'b0;

      if (w_tick) begin
         if (r_state != S_IDLE) begin
            if (r_samp_ctr == C_PRE) w_v0_next = w_rx_s;
            if (r_samp_ctr == C_MID) w_v1_next = w_rx_s;
            w_samp_next = (r_samp_ctr == C_LAST) ? '0 : r_samp_ctr + 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (!w_rx_s) begin
                  w_state_next    = S_START;
                  w_samp_next     = '0;
                  w_par_mode_next = parity_mode;
                  w_two_stop_next = two_stop;
               end
            end

            S_START: begin
               if (r_samp_ctr == C_DEC && w_vote) begin
                  // glitch: line was high at mid-bit
                  w_state_next = S_IDLE;
                  w_samp_next  = '0;
               end else if (r_samp_ctr == C_LAST) begin
                  w_state_next = S_DATA;
                  w_bit_next   = '0;
               end
            end

            S_DATA: begin
               if (r_samp_ctr == C_DEC)
                  w_shift_next = {w_vote, r_shift[DATA_BITS-1:1]};
               if (r_samp_ctr == C_LAST) begin
                  w_bit_next = r_bit_ctr + 1'b1;
                  if (r_bit_ctr == B_LAST) begin
                     w_state_next = w_par_en ? S_PARITY : S_STOP;
                     w_stop_next  = 1'b0;
                  end
               end
            end

            S_PARITY: begin
               if (r_samp_ctr == C_DEC)
                  w_par_bit_next = w_vote;
               if (r_samp_ctr == C_LAST) begin
                  w_state_next = S_STOP;
                  w_stop_next  = 1'b0;
               end
            end

            S_STOP: begin
               if (r_samp_ctr == C_DEC) begin
                  if (!w_vote) begin
                     w_frame_err_next = 1'b1;
                     w_state_next     = S_IDLE;
                     w_samp_next      = '0;
                  end else if (r_stop_ctr == r_two_stop) begin
                     // Final stop bit: finish half a bit early so a
                     // back-to-back start edge is not missed.
                     w_state_next = S_IDLE;
                     w_samp_next  = '0;
                     if (w_par_en && w_par_fail) begin
                        w_parity_err_next = 1'b1;
                     end else if (r_rx_valid && !rx_ack) begin
                        w_overrun_err_next = 1'b1;
                     end else begin
                        w_rx_data_next  = r_shift;
                        w_rx_valid_next = 1'b1;
                     end
                  end
               end else if (r_samp_ctr == C_LAST) begin
                  w_stop_next = 1'b1;
               end
            end

            default: begin
               w_state_next = S_IDLE;
               w_samp_next  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1       <= 1'b1;
         r_sync2       <= 1'b1;
         r_tick_cnt    <= '0;
         r_state       <= S_IDLE;
         r_samp_ctr    <= '0;
         r_bit_ctr     <= '0;
         r_stop_ctr    <= 1'b0;
         r_v0          <= 1'b0;
         r_v1          <= 1'b0;
         r_shift       <= '0;
         r_par_bit     <= 1'b0;
         r_par_mode    <= 2'b00;
         r_two_stop    <= 1'b0;
         r_rx_data     <= '0;
         r_rx_valid    <= 1'b0;
         r_parity_err  <= 1'b0;
         r_frame_err   <= 1'b0;
         r_overrun_err <= 1'b0;
      end else begin
         r_sync1       <= rx_line;
         r_sync2       <= r_sync1;
         r_tick_cnt    <= w_tick ? '0 : r_tick_cnt + 1'b1;
         r_state       <= w_state_next;
         r_samp_ctr    <= w_samp_next;
         r_bit_ctr     <= w_bit_next;
         r_stop_ctr    <= w_stop_next;
         r_v0          <= w_v0_next;
         r_v1          <= w_v1_next;
         r_shift       <= w_shift_next;
         r_par_bit     <= w_par_bit_next;
         r_par_mode    <= w_par_mode_next;
         r_two_stop    <= w_two_stop_next;
         r_rx_data     <= w_rx_data_next;
         r_rx_valid    <= w_rx_valid_next;
         r_parity_err  <= w_parity_err_next;
         r_frame_err   <= w_frame_err_next;
         r_overrun_err <= w_overrun_err_next;
      end
   end

   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign parity_err  = r_parity_err;
   assign frame_err   = r_frame_err;
   assign overrun_err = r_overrun_err;
   assign busy        = (r_state != S_IDLE);

endmodule
